// File: rtl/micro_sequencer_if.sv
// Host, ROM and ALU bundle for micro_sequencer.
// Step/halt signals exist only with MICRO_SEQUENCER_STEP_EN.
interface micro_sequencer_if #(
    parameter int AW = 6,
    parameter int DW = 8,
    parameter int IW = 19
);
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] end_addr;
    logic          busy;
    logic          done;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_data;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_sel;
    logic          alu_cin;
    logic [DW-1:0] alu_y;
    logic [1:0]    rd_addr;
    logic [DW-1:0] rd_data;
`ifdef MICRO_SEQUENCER_STEP_EN
    logic          step_mode;
    logic          step;
    logic          halted;
`endif

    modport master (
        input  start, start_addr, end_addr,
        input  rom_data, alu_y, rd_addr,
`ifdef MICRO_SEQUENCER_STEP_EN
        input  step_mode, step,
        output halted,
`endif
        output busy, done, rom_addr,
        output alu_a, alu_b, alu_sel, alu_cin,
        output rd_data
    );

    modport slave (
        output start, start_addr, end_addr,
        output rom_data, alu_y, rd_addr,
`ifdef MICRO_SEQUENCER_STEP_EN
        output step_mode, step,
        input  halted,
`endif
        input  busy, done, rom_addr,
        input  alu_a, alu_b, alu_sel, alu_cin,
        input  rd_data
    );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram controller: fetch/exec/write over a 4x8 regfile.
// Optional single-step HOLD state under MICRO_SEQUENCER_STEP_EN.
module micro_sequencer #(
    parameter int AW = 6,
    parameter int DW = 8,
    parameter int IW = 19
) (
    input  logic             clock,
    input  logic             reset,
    micro_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        WRITE,
`ifdef MICRO_SEQUENCER_STEP_EN
        HOLD,
`endif
        DONE
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [AW-1:0] pc;
    logic [IW-1:0] ir;
    logic [DW-1:0] result;
    logic [DW-1:0] regs [4];

    logic [2:0]    op;
    logic [1:0]    dst;
    logic [1:0]    src_a;
    logic [1:0]    src_b;
    logic          imm_sel;
    logic          cin;
    logic [DW-1:0] imm;
    logic          at_end;

    assign op      = ir[18:16];
    assign dst     = ir[15:14];
    assign src_a   = ir[13:12];
    assign src_b   = ir[11:10];
    assign imm_sel = ir[9];
    assign cin     = ir[8];
    assign imm     = ir[7:0];
    assign at_end  = (pc == bus.end_addr);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  if (bus.start) nxt = FETCH;
            FETCH: nxt = EXEC;
            EXEC:  nxt = WRITE;
            WRITE: begin
                if (at_end) nxt = DONE;
`ifdef MICRO_SEQUENCER_STEP_EN
                else if (bus.step_mode) nxt = HOLD;
`endif
                else nxt = FETCH;
            end
`ifdef MICRO_SEQUENCER_STEP_EN
            HOLD:  if (bus.step || !bus.step_mode) nxt = FETCH;
`endif
            DONE:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.rom_addr = '0;
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_sel  = '0;
        bus.alu_cin  = 1'b0;
`ifdef MICRO_SEQUENCER_STEP_EN
        bus.halted   = 1'b0;
`endif
        unique case (state)
            FETCH: begin
                bus.busy     = 1'b1;
                bus.rom_addr = pc;
            end
            EXEC: begin
                bus.busy    = 1'b1;
                bus.alu_a   = regs[src_a];
                bus.alu_b   = imm_sel ? imm : regs[src_b];
                bus.alu_sel = op;
                bus.alu_cin = cin;
            end
            WRITE: bus.busy = 1'b1;
`ifdef MICRO_SEQUENCER_STEP_EN
            HOLD: begin
                bus.busy   = 1'b1;
                bus.halted = 1'b1;
            end
`endif
            DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    // pc advances in WRITE so a HOLD resumes at the next microword
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc     <= '0;
            ir     <= '0;
            result <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            unique case (state)
                IDLE:  if (bus.start) pc <= bus.start_addr;
                FETCH: ir <= bus.rom_data;
                EXEC:  result <= bus.alu_y;
                WRITE: begin
                    regs[dst] <= result;
                    if (!at_end) pc <= pc + AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_data = regs[bus.rd_addr];

endmodule

// File: tb/tb_micro_sequencer.sv
// Randomized bench for micro_sequencer with a cycle-level
// instruction model plus hand-computed program results.
module tb_micro_sequencer;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int IW = 19;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    micro_sequencer_if #(.AW(AW), .DW(DW), .IW(IW)) bus ();

    micro_sequencer #(.AW(AW), .DW(DW), .IW(IW)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    logic [IW-1:0] rom [64];
    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] alu(input logic [2:0] op,
                                       input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic c);
        case (op)
            3'd0: return a + b + 8'(c);
            3'd1: return a << 1;
            3'd2: return a >> 1;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return a ^ b;
            3'd6: return ~a;
            default: return b;
        endcase
    endfunction

    assign bus.rom_data = rom[bus.rom_addr];
    assign bus.alu_y = alu(bus.alu_sel, bus.alu_a, bus.alu_b, bus.alu_cin);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: a run of N microwords lasts 3N busy cycles then one done
    bit       m_run = 1'b0;
    int       m_k = 0;
    int       m_n = 0;
    int       m_sa = 0;
    logic [7:0] mregs [4];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_run <= 1'b0;
            m_k   <= 0;
        end else if (m_run) begin
            if (m_k == 3 * m_n + 1) m_run <= 1'b0;
            else m_k <= m_k + 1;
        end else if (bus.start) begin
            m_run <= 1'b1;
            m_k   <= 1;
            m_sa  <= int'(bus.start_addr);
            m_n   <= ((int'(bus.end_addr) - int'(bus.start_addr)) & 63) + 1;
        end
    end

    int         c_i;
    int         c_ph;
    logic [5:0] c_addr;
    logic [18:0] c_w;
    logic [7:0] c_b;

    task automatic alu_zero();
        chk("alu_a_idle", 32'(bus.alu_a), 0);
        chk("alu_b_idle", 32'(bus.alu_b), 0);
        chk("alu_sel_idle", 32'(bus.alu_sel), 0);
        chk("alu_cin_idle", 32'(bus.alu_cin), 0);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
            chk("rst_busy", 32'(bus.busy), 0);
            chk("rst_done", 32'(bus.done), 0);
            chk("rst_rom_addr", 32'(bus.rom_addr), 0);
            alu_zero();
        end else if (!m_run) begin
            chk("idle_busy", 32'(bus.busy), 0);
            chk("idle_done", 32'(bus.done), 0);
            chk("idle_rom_addr", 32'(bus.rom_addr), 0);
            alu_zero();
        end else if (m_k == 3 * m_n + 1) begin
            chk("done_busy", 32'(bus.busy), 0);
            chk("done_pulse", 32'(bus.done), 1);
            alu_zero();
        end else begin
            c_i = (m_k - 1) / 3;
            c_ph = (m_k - 1) % 3;
            c_addr = 6'((m_sa + c_i) % 64);
            c_w = rom[c_addr];
            c_b = c_w[9] ? c_w[7:0] : mregs[c_w[11:10]];
            chk("run_busy", 32'(bus.busy), 1);
            chk("run_done", 32'(bus.done), 0);
            if (c_ph == 0) begin
                chk("fetch_rom_addr", 32'(bus.rom_addr), 32'(c_addr));
                alu_zero();
            end else if (c_ph == 1) begin
                chk("exec_rom_addr", 32'(bus.rom_addr), 0);
                chk("exec_alu_a", 32'(bus.alu_a), 32'(mregs[c_w[13:12]]));
                chk("exec_alu_b", 32'(bus.alu_b), 32'(c_b));
                chk("exec_alu_sel", 32'(bus.alu_sel), 32'(c_w[18:16]));
                chk("exec_alu_cin", 32'(bus.alu_cin), 32'(c_w[8]));
            end else begin
                chk("write_rom_addr", 32'(bus.rom_addr), 0);
                alu_zero();
            end
        end
        if (reset) chk("rd_data", 32'(bus.rd_data), 32'(mregs[bus.rd_addr]));
        // register update becomes visible the cycle after WRITE
        if (reset && m_run && m_k != 3 * m_n + 1 && c_ph == 2)
            mregs[c_w[15:14]] = alu(c_w[18:16], mregs[c_w[13:12]],
                                    c_b, c_w[8]);
    end

    task automatic tick();
        @(posedge clock);
        #2;
        bus.rd_addr = 2'($urandom);
    endtask

    task automatic rdchk(input logic [1:0] idx, input logic [7:0] exp,
                         input string nm);
        bus.rd_addr = idx;
        #1;
        chk(nm, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic run(input logic [5:0] sa, input logic [5:0] ea,
                       input bit pulses, output int cyc);
        bus.start_addr = sa;
        bus.end_addr = ea;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 300) begin
            bus.start = pulses && m_run && (m_k < 3 * m_n) &&
                        ($urandom_range(0, 2) == 0);
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        if (cyc >= 300) chk("done_timeout", 32'(cyc), 0);
        tick();
    endtask

    function automatic logic [18:0] mw(input logic [2:0] op,
                                       input logic [1:0] d,
                                       input logic [1:0] a,
                                       input logic [1:0] b,
                                       input logic is,
                                       input logic c,
                                       input logic [7:0] im);
        return {op, d, a, b, is, c, im};
    endfunction

    int cyc;
    int len;
    logic [5:0] sa;

    initial begin
        bus.start = 1'b0;
        bus.start_addr = '0;
        bus.end_addr = '0;
        bus.rd_addr = '0;
`ifdef MICRO_SEQUENCER_STEP_EN
        bus.step_mode = 1'b0;
        bus.step = 1'b0;
`endif
        for (int i = 0; i < 64; i++) rom[i] = '0;

        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("idle_busy_lit", 32'(bus.busy), 0);
        chk("idle_done_lit", 32'(bus.done), 0);
        chk("idle_rom_lit", 32'(bus.rom_addr), 0);
        for (int i = 0; i < 4; i++) rdchk(2'(i), 8'h00, "reset_reg");

        rom[0] = mw(3'b111, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 8'h05);
        run(6'd0, 6'd0, 1'b0, cyc);
        chk("single_cycles", 32'(cyc), 4);
        rdchk(2'd0, 8'h05, "single_r0");

        rom[0] = mw(3'b111, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 8'h0F);
        rom[1] = mw(3'b000, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 8'h00);
        rom[2] = mw(3'b101, 2'd3, 2'd2, 2'd0, 1'b1, 1'b0, 8'hFF);
        run(6'd0, 6'd2, 1'b0, cyc);
        chk("prog_cycles", 32'(cyc), 10);
        rdchk(2'd1, 8'h0F, "prog_r1");
        rdchk(2'd2, 8'h15, "prog_r2");
        rdchk(2'd3, 8'hEA, "prog_r3");

        rom[63] = mw(3'b111, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 8'h01);
        rom[0] = mw(3'b000, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00);
        run(6'd63, 6'd0, 1'b0, cyc);
        chk("wrap_cycles", 32'(cyc), 7);
        rdchk(2'd0, 8'h02, "wrap_r0");

        rom[5] = mw(3'b111, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 8'hFF);
        rom[6] = mw(3'b000, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 8'h01);
        run(6'd5, 6'd6, 1'b1, cyc);
        chk("ovf_cycles", 32'(cyc), 7);
        rdchk(2'd0, 8'h00, "ovf_r0");

        bus.start_addr = 6'd5;
        bus.end_addr = 6'd6;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 0);
        for (int i = 0; i < 4; i++) rdchk(2'(i), 8'h00, "midrst_reg");
        tick();
        tick();
        reset = 1'b1;
        tick();
        run(6'd5, 6'd6, 1'b0, cyc);
        chk("rerun_cycles", 32'(cyc), 7);
        rdchk(2'd0, 8'h00, "rerun_r0");

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 64; i++) rom[i] = 19'($urandom);
            sa = 6'($urandom);
            len = $urandom_range(1, 6);
            run(sa, 6'((int'(sa) + len - 1) % 64), 1'b1, cyc);
            chk("rand_cycles", 32'(cyc), 32'(3 * len + 1));
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
